// File: rtl/dsss_spreader.sv
// Direct-sequence spreader: a one-bit data stream is spread with a 63-chip
// m-sequence and emitted as a +/-AMP baseband sample stream. Each burst is an
// all-ones preamble followed by data drawn from a one-deep holding register.
// The burst ends when a bit boundary finds the holding register empty.
module dsss_spreader #(
    parameter int unsigned CHIP_DIV = 8,
    parameter int unsigned PRE_BITS = 16,
    parameter int          AMP      = 8191
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               pn,
    output logic signed [14:0] dout,
    output logic               bit_sync,
    output logic               tx_active,
    output logic               underrun
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CHIP_W = 6;
    localparam int unsigned LFSR_W = 6;
    localparam int unsigned DOUT_W = 15;

    localparam logic [CNT_W-1:0]         DIV_LAST  = CNT_W'(CHIP_DIV - 1);
    localparam logic [CNT_W-1:0]         PRE_LAST  = CNT_W'(PRE_BITS - 1);
    localparam logic [CHIP_W-1:0]        CHIP_LAST = CHIP_W'(62);
    localparam logic [LFSR_W-1:0]        LFSR_SEED = LFSR_W'(1);
    localparam logic signed [DOUT_W-1:0] AMP_POS   = DOUT_W'(AMP);
    localparam logic signed [DOUT_W-1:0] AMP_NEG   = -AMP_POS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [CHIP_W-1:0]   chip_q, chip_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic                cur_bit_q, cur_bit_d;
    logic                hold_full_q, hold_full_d;
    logic                hold_bit_q, hold_bit_d;

    logic                chip_strobe;
    logic                bit_end;
    logic                load;
    logic                transfer;
    logic                active_d;
    logic                underrun_d;
    logic                pn_d;
    logic                bit_sync_d;
    logic signed [DOUT_W-1:0] dout_d;

    // Chip strobe ends each chip; the strobe on chip 62 ends the bit period.
    assign chip_strobe = (div_q == DIV_LAST);
    assign bit_end     = chip_strobe && (chip_q == CHIP_LAST);

    // Burst sequencing, chip timing, PN generation and holding register update.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        chip_d      = chip_q;
        lfsr_d      = lfsr_q;
        pre_cnt_d   = pre_cnt_q;
        cur_bit_d   = cur_bit_q;
        hold_full_d = hold_full_q;
        hold_bit_d  = hold_bit_q;
        load        = 1'b0;
        underrun_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d     = '0;
                chip_d    = '0;
                lfsr_d    = LFSR_SEED;
                pre_cnt_d = '0;
                cur_bit_d = 1'b1;
                if (start) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE, ST_DATA: begin
                div_d = chip_strobe ? '0 : div_q + CNT_W'(1);
                if (chip_strobe) begin
                    chip_d = bit_end ? '0 : chip_q + CHIP_W'(1);
                    lfsr_d = bit_end ? LFSR_SEED : {lfsr_q[0] ^ lfsr_q[1], lfsr_q[5:1]};
                end
                // Boundary decision uses the holding register as it stood
                // before any transfer landing in this same cycle.
                if (bit_end) begin
                    if ((state_q == ST_PRE) && (pre_cnt_q != PRE_LAST)) begin
                        pre_cnt_d = pre_cnt_q + CNT_W'(1);
                    end else if (hold_full_q) begin
                        state_d   = ST_DATA;
                        cur_bit_d = hold_bit_q;
                        load      = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load and transfer never coincide: a transfer needs an empty register.
        transfer = din_valid && !hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (transfer) begin
            hold_full_d = 1'b1;
            hold_bit_d  = din;
        end
    end

    // Output values for the next cycle, derived from next-state values so that
    // pn, dout and bit_sync stay aligned with the chip they describe.
    always_comb begin
        active_d   = (state_d != ST_IDLE);
        pn_d       = active_d && lfsr_d[0];
        bit_sync_d = active_d && (div_d == '0) && (chip_d == '0);
        dout_d     = '0;
        if (active_d) begin
            dout_d = (cur_bit_d ^ lfsr_d[0]) ? AMP_NEG : AMP_POS;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            chip_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            pre_cnt_q   <= '0;
            cur_bit_q   <= 1'b1;
            hold_full_q <= 1'b0;
            hold_bit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            chip_q      <= chip_d;
            lfsr_q      <= lfsr_d;
            pre_cnt_q   <= pre_cnt_d;
            cur_bit_q   <= cur_bit_d;
            hold_full_q <= hold_full_d;
            hold_bit_q  <= hold_bit_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            din_ready <= 1'b1;
            pn        <= 1'b0;
            dout      <= '0;
            bit_sync  <= 1'b0;
            tx_active <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            din_ready <= !hold_full_d;
            pn        <= pn_d;
            dout      <= dout_d;
            bit_sync  <= bit_sync_d;
            tx_active <= active_d;
            underrun  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_dsss_spreader.sv
// Bench for dsss_spreader: a default-parameter instance exercised per scenario
// against a sequence-level burst model, and a fast instance (CHIP_DIV=2,
// PRE_BITS=1) fed with random gaps and decoded by a correlating despreader.
module tb_dsss_spreader;

    localparam int CD_A  = 8;
    localparam int PB_A  = 16;
    localparam int BIT_A = 63 * CD_A;
    localparam int CD_B  = 2;
    localparam int BIT_B = 63 * CD_B;
    localparam int N_RND = 40;
    localparam logic signed [14:0] AMP_V = 15'sd8191;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_start, a_din, a_din_valid, a_din_ready, a_pn, a_bit_sync, a_tx_active, a_underrun;
    logic signed [14:0] a_dout;
    logic b_rst, b_start, b_din, b_din_valid, b_din_ready, b_pn, b_bit_sync, b_tx_active, b_underrun;
    logic signed [14:0] b_dout;

    dsss_spreader u_dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .din(a_din), .din_valid(a_din_valid),
        .din_ready(a_din_ready), .pn(a_pn), .dout(a_dout), .bit_sync(a_bit_sync),
        .tx_active(a_tx_active), .underrun(a_underrun)
    );

    dsss_spreader #(.CHIP_DIV(CD_B), .PRE_BITS(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .din(b_din), .din_valid(b_din_valid),
        .din_ready(b_din_ready), .pn(b_pn), .dout(b_dout), .bit_sync(b_bit_sync),
        .tx_active(b_tx_active), .underrun(b_underrun)
    );

    int total = 0;
    int bad   = 0;

    bit pn_seq[63];
    bit exp_bits[$];
    bit feed_q[$];
    logic signed [14:0] cap[$];

    // m-sequence of x^6+x+1 written as s[n+6] = s[n] ^ s[n+1], s[0..5] = 1,0,0,0,0,0
    function automatic void build_pn();
        for (int n = 0; n < 6; n++) pn_seq[n] = (n == 0);
        for (int n = 0; n < 57; n++) pn_seq[n+6] = pn_seq[n] ^ pn_seq[n+1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_preamble_bits();
        exp_bits.delete();
        for (int i = 0; i < PB_A; i++) exp_bits.push_back(1'b1);
    endtask

    // Runs instance A for one burst that began on the previous edge, checking
    // every cycle against the burst model; feeds feed_q as data is requested.
    task automatic check_burst(input int n_bits, input bit cont, input int late_t, input bit late_b,
                               input int start_t, input int stop_t, input string name);
        int t, b, chip, nerr, rerr;
        bit cur, ep, ebs, ert;
        logic signed [14:0] ed;
        string first;
        t = 0; nerr = 0; rerr = 0; first = "";
        cap.delete();
        while (t < n_bits * BIT_A && t != stop_t) begin
            b    = t / BIT_A;
            chip = (t / CD_A) % 63;
            cur  = exp_bits[b];
            ep   = pn_seq[chip];
            ed   = (cur ^ ep) ? -AMP_V : AMP_V;
            ebs  = ((t % BIT_A) == 0);
            cap.push_back(a_dout);
            if ({a_tx_active, a_bit_sync, a_underrun, a_pn, a_dout} !== {1'b1, ebs, 1'b0, ep, ed}) begin
                if (nerr == 0)
                    first = $sformatf("t=%0d got tx=%b bs=%b ur=%b pn=%b dout=%0d want tx=1 bs=%b ur=0 pn=%b dout=%0d",
                                      t, a_tx_active, a_bit_sync, a_underrun, a_pn, a_dout, ebs, ep, ed);
                nerr++;
            end
            if (cont) begin
                ert = (t >= PB_A * BIT_A) && (((t % BIT_A) == 0) || (t >= (n_bits - 1) * BIT_A));
                if (a_din_ready !== ert) rerr++;
            end
            if ((t % BIT_A) == BIT_A - 1) begin
                total++;
                if (nerr != 0) begin
                    bad++;
                    $display("FAIL %s bit %0d: %0d bad cycles, first %s", name, b, nerr, first);
                end
                nerr = 0;
            end
            a_start = (t == start_t);
            if (t == late_t) begin
                a_din_valid = 1'b1;
                a_din       = late_b;
            end else if (feed_q.size() > 0 && (cont || a_din_ready === 1'b1)) begin
                a_din_valid = 1'b1;
                a_din       = feed_q[0];
                if (a_din_ready === 1'b1) void'(feed_q.pop_front());
            end else begin
                a_din_valid = 1'b0;
            end
            step();
            t++;
        end
        a_din_valid = 1'b0;
        a_start     = 1'b0;
        if (cont) begin
            total++;
            if (rerr != 0) begin
                bad++;
                $display("FAIL %s din_ready: %0d cycles wrong, required 0", name, rerr);
            end
        end
        if (t == stop_t) begin
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL %s partial bit: %0d bad cycles, first %s", name, nerr, first);
            end
        end else begin
            total++;
            if ({a_underrun, a_tx_active, a_bit_sync, a_pn, a_dout} !== {1'b1, 1'b0, 1'b0, 1'b0, 15'sd0}) begin
                bad++;
                $display("FAIL %s end: ur=%b tx=%b bs=%b pn=%b dout=%0d required ur=1 tx=0 bs=0 pn=0 dout=0",
                         name, a_underrun, a_tx_active, a_bit_sync, a_pn, a_dout);
            end
            step();
            total++;
            if (a_underrun !== 1'b0) begin
                bad++;
                $display("FAIL %s underrun width: got %b required 0", name, a_underrun);
            end
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_start = 1'b1; b_start = 1'b1; a_din_valid = 1'b1; b_din_valid = 1'b1; a_din = 1'b1; b_din = 1'b1;
        step(); step();
        total++; if (a_din_ready !== 1'b1) begin bad++; $display("FAIL reset din_ready: got %b required 1", a_din_ready); end
        total++; if (a_pn !== 1'b0) begin bad++; $display("FAIL reset pn: got %b required 0", a_pn); end
        total++; if (a_dout !== 15'sd0) begin bad++; $display("FAIL reset dout: got %0d required 0", a_dout); end
        total++; if (a_bit_sync !== 1'b0) begin bad++; $display("FAIL reset bit_sync: got %b required 0", a_bit_sync); end
        total++; if (a_tx_active !== 1'b0) begin bad++; $display("FAIL reset tx_active: got %b required 0", a_tx_active); end
        total++; if (a_underrun !== 1'b0) begin bad++; $display("FAIL reset underrun: got %b required 0", a_underrun); end
        total++; if ({b_tx_active, b_dout, b_din_ready} !== {1'b0, 15'sd0, 1'b1}) begin
            bad++; $display("FAIL reset inst_b: tx=%b dout=%0d rdy=%b required 0 0 1", b_tx_active, b_dout, b_din_ready);
        end
        a_start = 1'b0; b_start = 1'b0; a_din_valid = 1'b0; b_din_valid = 1'b0; a_din = 1'b0; b_din = 1'b0;
        a_rst = 1'b1; b_rst = 1'b1;
        step();
        total++; if ({a_tx_active, a_din_ready} !== 2'b01) begin
            bad++; $display("FAIL idle after release: tx=%b rdy=%b required 0 1", a_tx_active, a_din_ready);
        end
    endtask

    task automatic test_preamble_underrun();
        set_preamble_bits();
        feed_q.delete();
        a_start = 1'b1;
        step();
        total++; if ({a_tx_active, a_bit_sync, a_pn, a_dout} !== {1'b1, 1'b1, 1'b1, AMP_V}) begin
            bad++; $display("FAIL first chip: tx=%b bs=%b pn=%b dout=%0d required 1 1 1 %0d",
                            a_tx_active, a_bit_sync, a_pn, a_dout, AMP_V);
        end
        check_burst(PB_A, 1'b0, -1, 1'b0, -1, -1, "preamble_only");
    endtask

    task automatic test_data();
        logic signed [14:0] want[7];
        want = '{-AMP_V, AMP_V, AMP_V, AMP_V, AMP_V, AMP_V, -AMP_V};
        a_din = 1'b0; a_din_valid = 1'b1;
        step();
        a_din_valid = 1'b0;
        total++; if (a_din_ready !== 1'b0) begin bad++; $display("FAIL preload din_ready: got %b required 0", a_din_ready); end
        set_preamble_bits();
        exp_bits.push_back(1'b0); exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
        feed_q.delete();
        feed_q.push_back(1'b1); feed_q.push_back(1'b0); feed_q.push_back(1'b1); feed_q.push_back(1'b1);
        a_start = 1'b1;
        step();
        check_burst(PB_A + 5, 1'b0, -1, 1'b0, -1, -1, "data_1011");
        for (int k = 0; k < 7; k++) begin
            total++;
            if (cap[PB_A * BIT_A + k * CD_A] !== want[k]) begin
                bad++;
                $display("FAIL data chip %0d: got %0d required %0d", k, cap[PB_A * BIT_A + k * CD_A], want[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_preamble_bits();
        feed_q.delete();
        for (int i = 0; i < 5; i++) begin
            feed_q.push_back(1'($urandom_range(0, 1)));
            exp_bits.push_back(feed_q[i]);
        end
        a_din = feed_q[0]; a_din_valid = 1'b1;
        step();
        void'(feed_q.pop_front());
        a_din = feed_q[0];
        a_start = 1'b1;
        step();
        check_burst(PB_A + 5, 1'b1, -1, 1'b0, -1, -1, "back_to_back");
    endtask

    task automatic test_boundary_underrun();
        set_preamble_bits();
        feed_q.delete();
        a_start = 1'b1;
        step();
        check_burst(PB_A, 1'b0, PB_A * BIT_A - 1, 1'b0, -1, -1, "boundary_offer");
        total++; if (a_din_ready !== 1'b0) begin bad++; $display("FAIL boundary bit kept: din_ready=%b required 0", a_din_ready); end
        total++; if (a_tx_active !== 1'b0) begin bad++; $display("FAIL boundary idle: tx_active=%b required 0", a_tx_active); end
        set_preamble_bits();
        exp_bits.push_back(1'b0);
        a_start = 1'b1;
        step();
        check_burst(PB_A + 1, 1'b0, -1, 1'b0, -1, -1, "kept_bit_burst");
    endtask

    task automatic test_start_ignored_and_reset();
        int idle_err;
        a_din = 1'b1; a_din_valid = 1'b1;
        step();
        a_din_valid = 1'b0;
        set_preamble_bits();
        exp_bits.push_back(1'b1); exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
        feed_q.delete();
        feed_q.push_back(1'b0); feed_q.push_back(1'b1);
        a_start = 1'b1;
        step();
        check_burst(PB_A + 3, 1'b0, -1, 1'b0, 1000, PB_A * BIT_A + 700, "start_ignored");
        a_rst = 1'b0;
        step();
        a_rst = 1'b1;
        total++; if ({a_din_ready, a_pn, a_dout, a_bit_sync, a_tx_active, a_underrun} !== {1'b1, 1'b0, 15'sd0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL mid reset: rdy=%b pn=%b dout=%0d bs=%b tx=%b ur=%b required 1 0 0 0 0 0",
                            a_din_ready, a_pn, a_dout, a_bit_sync, a_tx_active, a_underrun);
        end
        idle_err = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if ({a_tx_active, a_bit_sync, a_din_ready} !== 3'b001) idle_err++;
        end
        total++; if (idle_err != 0) begin bad++; $display("FAIL post reset idle: %0d bad cycles required 0", idle_err); end
        feed_q.delete();
    endtask

    task automatic test_random();
        bit acc[$];
        bit rec[$];
        int t, gap, nsent, corr, ones, perr, chip;
        acc.delete(); rec.delete();
        b_din = 1'($urandom_range(0, 1)); b_din_valid = 1'b1;
        step();
        acc.push_back(b_din);
        b_din_valid = 1'b0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        t = 0; nsent = 1; gap = $urandom_range(0, 50); corr = 0; ones = 0; perr = 0;
        while (b_underrun !== 1'b1 && t < (N_RND + 3) * BIT_B) begin
            chip = (t / CD_B) % 63;
            if (b_pn !== pn_seq[chip]) perr++;
            if (t < BIT_B && (t % CD_B) == 0 && b_pn === 1'b1) ones++;
            corr += pn_seq[chip] ? -int'(b_dout) : int'(b_dout);
            if ((t % BIT_B) == BIT_B - 1) begin
                rec.push_back(corr < 0);
                corr = 0;
            end
            b_din_valid = 1'b0;
            if (nsent < N_RND && b_din_ready === 1'b1) begin
                if (gap == 0) begin
                    b_din = 1'($urandom_range(0, 1));
                    b_din_valid = 1'b1;
                    acc.push_back(b_din);
                    nsent++;
                    gap = $urandom_range(0, 50);
                end else begin
                    gap--;
                end
            end
            step();
            t++;
        end
        b_din_valid = 1'b0;
        total++; if (b_underrun !== 1'b1) begin bad++; $display("FAIL random end: underrun=%b required 1 (timeout)", b_underrun); end
        total++; if (t != (N_RND + 1) * BIT_B) begin bad++; $display("FAIL random length: %0d clocks required %0d", t, (N_RND + 1) * BIT_B); end
        total++; if (perr != 0) begin bad++; $display("FAIL random pn: %0d bad chips required 0", perr); end
        total++; if (ones != 32) begin bad++; $display("FAIL pn ones: got %0d required 32", ones); end
        total++; if (rec.size() != N_RND + 1) begin bad++; $display("FAIL random bit count: got %0d required %0d", rec.size(), N_RND + 1); end
        if (rec.size() > 0) begin
            total++; if (rec[0] !== 1'b1) begin bad++; $display("FAIL random preamble: got %b required 1", rec[0]); end
        end
        for (int i = 0; i < acc.size() && i + 1 < rec.size(); i++) begin
            total++;
            if (rec[i+1] !== acc[i]) begin bad++; $display("FAIL random bit %0d: got %b required %b", i, rec[i+1], acc[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; a_start = 1'b0; a_din = 1'b0; a_din_valid = 1'b0;
        b_rst = 1'b0; b_start = 1'b0; b_din = 1'b0; b_din_valid = 1'b0;
        build_pn();
        #1;
        test_reset();
        test_preamble_underrun();
        test_data();
        test_back_to_back();
        test_boundary_underrun();
        test_start_ignored_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
